// File: rtl/uart_report_mux.sv
// UART command decoder, loopback echo and per-channel ASCII decimal report engine feeding a TX FIFO.
// Echo pushed 1 cycle after rx_done and tx_start 2 cycles later; a full FIFO drops bytes/reports and flags overflow.
module uart_report_mux #(
  parameter int              N_CH       = 5,
  parameter int              DW         = 8,
  parameter int              FIFO_DEPTH = 16,
  parameter logic [N_CH-1:0] AUTO_MASK  = N_CH'(5'b11000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  input  logic                 sw_priority,
  input  logic [2:0]           sw_sel,
  input  logic [N_CH*DW-1:0]   ch_data,
  input  logic [N_CH-1:0]      ch_event,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic [2:0]           mode,
  output logic                 fifo_empty,
  output logic                 overflow
);

  function automatic int num_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  localparam int         D       = num_digits(DW);
  localparam int         L       = D + 4;
  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0] NCH3    = 3'(N_CH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] L_C     = (AW+1)'(L);

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_T = 8'h54;

  typedef enum logic [1:0] {R_IDLE, R_CONV, R_EMIT} rep_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT_HI, T_WAIT_LO} tx_state_t;

  logic [2:0]    r_mode;
  logic          r_ovf;
  logic          r_lb_vld;
  logic [7:0]    r_lb_dat;

  rep_state_t    r_rstate;
  logic [DW-1:0] r_rem;
  logic [2:0]    r_rep_ch;
  logic [2:0]    r_dig;
  logic [3:0]    r_cnt;
  logic [3:0]    r_idx;
  logic [3:0]    r_digits [D];

  tx_state_t     r_tstate;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_push_dat;
  logic          w_lb_drop;
  logic          w_emit_push;
  logic [7:0]    w_rep_byte;
  logic [DW-1:0] w_ch_val;
  logic [DW-1:0] w_pow;
  logic          w_ev_hit;
  logic          w_trig;
  logic          w_space_ok;
  logic          w_rep_drop;

  assign mode       = r_mode;
  assign overflow   = r_ovf;
  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign fifo_empty = w_empty;

  // FIFO: extra pointer MSB distinguishes full from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = (r_tstate == T_START) && !w_empty;

  assign w_lb_drop   = r_lb_vld && w_full && !w_pop;
  assign w_emit_push = (r_rstate == R_EMIT) && !r_lb_vld && (!w_full || w_pop);
  assign w_push      = (r_lb_vld && !w_lb_drop) || w_emit_push;
  assign w_push_dat  = r_lb_vld ? r_lb_dat : w_rep_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_dat;
  end

  always_comb begin
    w_ch_val = '0;
    w_ev_hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_mode == 3'(k + 1)) begin
        w_ch_val = ch_data[k*DW +: DW];
        w_ev_hit = ch_event[k] & AUTO_MASK[k];
      end
    end
  end

  // A loopback byte still in flight will take a slot too, so reserve room for it.
  assign w_trig     = (r_mode != 3'd0) && ((rx_done && rx_data == CH_T) || w_ev_hit);
  assign w_space_ok = (DEPTH_C - w_count) >= (L_C + {{AW{1'b0}}, r_lb_vld});
  assign w_rep_drop = (r_rstate == R_IDLE) && w_trig && !w_space_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 3'd0;
      r_ovf    <= 1'b0;
      r_lb_vld <= 1'b0;
      r_lb_dat <= 8'h00;
    end else begin
      r_lb_vld <= rx_done && (r_mode == 3'd0);
      r_lb_dat <= rx_data;
      if (sw_priority)
        r_mode <= (sw_sel > NCH3) ? 3'd0 : sw_sel;
      else if (rx_done && rx_data == CH_A)
        r_mode <= (r_mode >= NCH3) ? 3'd0 : r_mode + 3'd1;
      if (w_lb_drop || w_rep_drop)
        r_ovf <= 1'b1;
      else if (rx_done && rx_data == CH_C)
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_pow = '0;
    for (int i = 0; i < D; i++) begin
      if (r_dig == 3'(i)) w_pow = DW'(pow10(D - 1 - i));
    end
  end

  always_comb begin
    w_rep_byte = 8'h0A;
    if (r_idx == 4'd0)
      w_rep_byte = 8'h30 + {5'd0, r_rep_ch};
    else if (r_idx == 4'd1)
      w_rep_byte = 8'h3A;
    else if (r_idx == 4'(D + 2))
      w_rep_byte = 8'h0D;
    for (int i = 0; i < D; i++) begin
      if (r_idx == 4'(i + 2)) w_rep_byte = {4'h3, r_digits[i]};
    end
  end

  // Digit i counts how many times 10^(D-1-i) fits in the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rem    <= '0;
      r_rep_ch <= 3'd0;
      r_dig    <= 3'd0;
      r_cnt    <= 4'd0;
      r_idx    <= 4'd0;
      for (int i = 0; i < D; i++) r_digits[i] <= 4'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_trig && w_space_ok) begin
            r_rstate <= R_CONV;
            r_rem    <= w_ch_val;
            r_rep_ch <= r_mode;
            r_dig    <= 3'd0;
            r_cnt    <= 4'd0;
          end
        end
        R_CONV: begin
          if (r_rem >= w_pow) begin
            r_rem <= r_rem - w_pow;
            r_cnt <= r_cnt + 4'd1;
          end else begin
            for (int i = 0; i < D; i++) begin
              if (r_dig == 3'(i)) r_digits[i] <= r_cnt;
            end
            r_cnt <= 4'd0;
            if (r_dig == 3'(D - 1)) begin
              r_rstate <= R_EMIT;
              r_idx    <= 4'd0;
            end else begin
              r_dig <= r_dig + 3'd1;
            end
          end
        end
        R_EMIT: begin
          if (w_emit_push) begin
            if (r_idx == 4'(L - 1)) r_rstate <= R_IDLE;
            else                    r_idx    <= r_idx + 4'd1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tstate   <= T_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_tstate)
        T_IDLE: begin
          if (!w_empty && !tx_busy) begin
            r_tstate   <= T_START;
            r_tx_start <= 1'b1;
            r_tx_data  <= r_mem[r_rd_ptr[AW-1:0]];
          end
        end
        T_START:   r_tstate <= T_WAIT_HI;
        T_WAIT_HI: if (tx_busy)  r_tstate <= T_WAIT_LO;
        T_WAIT_LO: if (!tx_busy) r_tstate <= T_IDLE;
        default:   r_tstate <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_report_mux.sv
// Bench for uart_report_mux: mode-command vector table plus directed loopback, report, overflow and reset sequences.
module tb_uart_report_mux;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        sw_priority;
  logic [2:0]  sw_sel;
  logic [39:0] ch_data;
  logic [4:0]  ch_event;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [2:0]  mode;
  logic        fifo_empty;
  logic        overflow;

  uart_report_mux dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .sw_priority(sw_priority), .sw_sel(sw_sel), .ch_data(ch_data), .ch_event(ch_event),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .mode(mode),
    .fifo_empty(fifo_empty), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int overlap = 0;
  int busy_cnt = 0;
  logic stall;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  // Simple uart_tx model: busy for 4 cycles after each start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (tx_start) begin
      if (tx_busy) overlap++;
      cap_q.push_back(tx_data);
      busy_cnt <= 4;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = stall | (busy_cnt != 0);

  typedef struct {
    logic       sw_pri;
    logic [2:0] sw_sel;
    logic [7:0] rx;
    logic       echo;
    logic [2:0] exp_mode;
  } mvec_t;
  mvec_t tbl[12];

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic exp_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_drain();
    int quiet;
    int t;
    quiet = 0;
    t = 0;
    while (quiet < 40 && t < 3000) begin
      @(negedge clk);
      t++;
      if (fifo_empty && !tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    check("drain_done", int'(quiet >= 40), 1);
  endtask

  task automatic cmp_stream(input string nm);
    check({nm, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check(nm, cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int starts;

    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; sw_priority = 1'b0; sw_sel = 3'd0;
    ch_data = '0; ch_event = '0; stall = 1'b0;

    // sw_pri, sw_sel, byte, echoed, mode afterwards
    tbl[0]  = '{1'b0, 3'd0, 8'h41, 1'b1, 3'd1};
    tbl[1]  = '{1'b0, 3'd0, 8'h41, 1'b0, 3'd2};
    tbl[2]  = '{1'b0, 3'd0, 8'h78, 1'b0, 3'd2};
    tbl[3]  = '{1'b0, 3'd0, 8'h41, 1'b0, 3'd3};
    tbl[4]  = '{1'b0, 3'd0, 8'h41, 1'b0, 3'd4};
    tbl[5]  = '{1'b0, 3'd0, 8'h41, 1'b0, 3'd5};
    tbl[6]  = '{1'b0, 3'd0, 8'h41, 1'b0, 3'd0};
    tbl[7]  = '{1'b1, 3'd3, 8'h41, 1'b1, 3'd3};
    tbl[8]  = '{1'b1, 3'd7, 8'h43, 1'b0, 3'd0};
    tbl[9]  = '{1'b1, 3'd6, 8'h71, 1'b1, 3'd0};
    tbl[10] = '{1'b1, 3'd5, 8'h41, 1'b1, 3'd5};
    tbl[11] = '{1'b0, 3'd5, 8'h41, 1'b0, 3'd0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_overflow", overflow, 0);

    // Loopback with latency measurement
    send_byte(8'h68);
    lat = 1;
    while (!tx_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lb_latency", lat, 3);
    send_byte(8'h69);
    wait_drain();
    exp_str("hi");
    cmp_stream("lb_hi");
    check("lb_mode", mode, 0);
    check("lb_overflow", overflow, 0);

    // Mode command table
    for (int i = 0; i < 12; i++) begin
      sw_priority = tbl[i].sw_pri;
      sw_sel      = tbl[i].sw_sel;
      send_byte(tbl[i].rx);
      check($sformatf("mode_vec%0d", i), mode, tbl[i].exp_mode);
      if (tbl[i].echo) exp_q.push_back(tbl[i].rx);
    end
    sw_priority = 1'b0;
    wait_drain();
    cmp_stream("vec_echo");

    // Manual report of channel 2
    send_byte(8'h41);
    send_byte(8'h41);
    check("rep_mode", mode, 2);
    ch_data[15:8] = 8'd37;
    wait_drain();
    exp_str("A");
    cmp_stream("rep_pre");
    send_byte(8'h54);
    lat = 1;
    while (fifo_empty && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("rep_latency_ok", int'(lat <= 33), 1);
    wait_drain();
    exp_str("2:037");
    exp_crlf();
    cmp_stream("rep_ch2");

    // Auto report on channel 4, unselected event, T+event coincidence, busy re-trigger
    send_byte(8'h41);
    send_byte(8'h41);
    check("auto_mode", mode, 4);
    ch_data[31:24] = 8'd255;
    ch_event = 5'b01000;
    @(negedge clk);
    ch_event = 5'b00000;
    wait_drain();
    exp_str("4:255");
    exp_crlf();
    cmp_stream("auto_ch4");
    ch_event = 5'b00001;
    @(negedge clk);
    ch_event = 5'b00000;
    wait_drain();
    check("ev_unselected", cap_q.size(), 0);
    ch_data[31:24] = 8'd0;
    ch_event = 5'b01000;
    rx_data = 8'h54;
    rx_done = 1'b1;
    @(negedge clk);
    ch_event = 5'b00000;
    rx_done = 1'b0;
    send_byte(8'h54);
    wait_drain();
    exp_str("4:000");
    exp_crlf();
    cmp_stream("single_rec");
    check("busy_trig_no_ovf", overflow, 0);

    // Overflow: 17 bytes into a stalled 16-deep FIFO
    send_byte(8'h41);
    send_byte(8'h41);
    check("ovf_mode0", mode, 0);
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h61 + 8'(i));
      if (i < 16) exp_q.push_back(8'h61 + 8'(i));
    end
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_not_empty", fifo_empty, 0);
    sw_priority = 1'b1;
    sw_sel = 3'd4;
    @(negedge clk);
    check("sw_mode4", mode, 4);
    ch_event = 5'b01000;
    rx_data = 8'h43;
    rx_done = 1'b1;
    @(negedge clk);
    ch_event = 5'b00000;
    rx_done = 1'b0;
    check("ovf_set_wins", overflow, 1);
    send_byte(8'h43);
    check("ovf_cleared", overflow, 0);
    sw_sel = 3'd0;
    @(negedge clk);
    sw_priority = 1'b0;
    stall = 1'b0;
    wait_drain();
    cmp_stream("ovf_drain");

    // Report fits exactly: 9 queued bytes leave 7 free slots
    sw_priority = 1'b1;
    sw_sel = 3'd0;
    ch_data[7:0] = 8'd5;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h30 + 8'(i));
      exp_q.push_back(8'h30 + 8'(i));
    end
    sw_sel = 3'd1;
    @(negedge clk);
    send_byte(8'h54);
    repeat (40) @(negedge clk);
    check("fit_no_ovf", overflow, 0);
    stall = 1'b0;
    wait_drain();
    exp_str("1:005");
    exp_crlf();
    cmp_stream("fit_stream");

    // Report dropped: 10 queued bytes leave 6 free slots
    sw_sel = 3'd0;
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h61 + 8'(i));
      exp_q.push_back(8'h61 + 8'(i));
    end
    sw_sel = 3'd1;
    @(negedge clk);
    send_byte(8'h54);
    check("drop_ovf", overflow, 1);
    repeat (40) @(negedge clk);
    stall = 1'b0;
    wait_drain();
    cmp_stream("drop_stream");
    send_byte(8'h43);
    check("drop_ovf_clr", overflow, 0);

    // Switch override, then reset in the middle of a record
    sw_sel = 3'd7;
    @(negedge clk);
    check("sw7_mode", mode, 0);
    sw_sel = 3'd3;
    @(negedge clk);
    check("sw3_mode", mode, 3);
    ch_data[23:16] = 8'd123;
    send_byte(8'h54);
    lat = 0;
    while (fifo_empty && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("mid_emit_reached", int'(lat < 60), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_mode", mode, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_fifo_empty", fifo_empty, 1);
    check("mid_rst_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    sw_priority = 1'b0;
    rst = 1'b0;
    cap_q.delete();
    exp_q.delete();
    starts = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check("post_rst_starts", starts, 0);
    check("post_rst_capture", cap_q.size(), 0);
    check("post_rst_empty", fifo_empty, 1);
    check("post_rst_mode", mode, 0);

    check("start_while_busy", overlap, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
